// File: rtl/instr_loader.sv
// Boot-time program loader: assembles a framed big-endian byte stream into
// instruction words, writes them to imem, and releases the core on a good checksum.
module instr_loader #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [DATA_W-1:0] o_imem_wdata,
    output logic              o_cpu_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_words_loaded
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_len, w_len_nxt;
    logic [DATA_W-1:0]   r_word, w_word_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [7:0]          r_chk, w_chk_nxt;
    logic [1:0]          r_bidx, w_bidx_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [CNT_W-1:0]    r_wl, w_wl_nxt;
    logic                r_rx_ready;
    logic                r_we;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic                w_xfer;
    logic [15:0]         w_len_in;

    assign w_xfer   = i_rx_valid & r_rx_ready;
    assign w_len_in = {r_len[15:8], i_rx_data};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_word_nxt  = r_word;
        w_wdata_nxt = r_wdata;
        w_chk_nxt   = r_chk;
        w_bidx_nxt  = r_bidx;
        w_tmo_nxt   = r_tmo;
        w_addr_nxt  = r_addr;
        w_wl_nxt    = r_wl;

        // Idle-byte watchdog; a transfer below overrides the abort
        if (r_state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK}) begin
            if (w_xfer) begin
                w_tmo_nxt = '0;
            end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                w_state_nxt = S_ERROR;
            end else begin
                w_tmo_nxt = TMO_W'(r_tmo + 1'b1);
            end
        end

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_state_nxt = S_LEN_HI;
                    w_wl_nxt    = '0;
                    w_addr_nxt  = '0;
                    w_chk_nxt   = '0;
                    w_tmo_nxt   = '0;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    w_len_nxt   = {i_rx_data, r_len[7:0]};
                    w_state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    w_len_nxt  = w_len_in;
                    w_bidx_nxt = '0;
                    if (32'(w_len_in) > DEPTH)  w_state_nxt = S_ERROR;
                    else if (w_len_in == 16'd0) w_state_nxt = S_CHECK;
                    else                        w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    w_word_nxt = {r_word[DATA_W-9:0], i_rx_data};
                    w_chk_nxt  = r_chk ^ i_rx_data;
                    w_bidx_nxt = 2'(r_bidx + 2'd1);
                    if (r_bidx == 2'd3) begin
                        w_wdata_nxt = {r_word[DATA_W-9:0], i_rx_data};
                        w_state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_addr_nxt = ADDR_W'(r_addr + 1'b1);
                w_wl_nxt   = CNT_W'(r_wl + 1'b1);
                if (32'(r_wl) + 32'd1 == 32'(r_len)) w_state_nxt = S_CHECK;
                else                                  w_state_nxt = S_DATA;
            end
            S_CHECK: begin
                if (w_xfer) begin
                    w_state_nxt = (i_rx_data == r_chk) ? S_DONE : S_ERROR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and status outputs, all registered from the next state
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_len       <= '0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_chk       <= '0;
            r_bidx      <= '0;
            r_tmo       <= '0;
            r_addr      <= '0;
            r_wl        <= '0;
            r_rx_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_len       <= w_len_nxt;
            r_word      <= w_word_nxt;
            r_wdata     <= w_wdata_nxt;
            r_chk       <= w_chk_nxt;
            r_bidx      <= w_bidx_nxt;
            r_tmo       <= w_tmo_nxt;
            r_addr      <= w_addr_nxt;
            r_wl        <= w_wl_nxt;
            r_rx_ready  <= (w_state_nxt inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK});
            r_we        <= (w_state_nxt == S_WRITE);
            r_cpu_reset <= (w_state_nxt != S_DONE);
            r_busy      <= !(w_state_nxt inside {S_IDLE, S_DONE, S_ERROR});
            r_done      <= (w_state_nxt == S_DONE);
            r_error     <= (w_state_nxt == S_ERROR);
        end
    end

    assign o_rx_ready     = r_rx_ready;
    assign o_imem_we      = r_we;
    assign o_imem_addr    = r_addr;
    assign o_imem_wdata   = r_wdata;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_words_loaded = r_wl;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: frame-level model predicts writes and outcome,
// a negedge monitor checks every write and the status invariants.
module tb_instr_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned TMO    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;
    logic              o_cpu_reset;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [ADDR_W:0]   o_words_loaded;

    instr_loader #(.ADDR_W(ADDR_W), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
        .o_cpu_reset(o_cpu_reset), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_words_loaded(o_words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]       fw[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];
    logic              prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the next write the model predicted
    always @(negedge clk) begin
        if (rst_n) begin
            check("cpu_reset_is_not_done", 32'(o_cpu_reset), 32'(!o_done));
            check("done_error_exclusive", 32'(o_done & o_error), 32'd0);
            if (o_imem_we) begin
                check("we_single_cycle", 32'(prev_we), 32'd0);
                check("rx_ready_low_in_write", 32'(o_rx_ready), 32'd0);
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write actual_addr=0x%0h data=0x%0h expected=none",
                             o_imem_addr, o_imem_wdata);
                end else begin
                    check("write_addr", 32'(o_imem_addr), 32'(exp_addr.pop_front()));
                    check("write_data", o_imem_wdata, exp_data.pop_front());
                end
                log_addr.push_back(o_imem_addr);
                log_data.push_back(o_imem_wdata);
            end
            prev_we = o_imem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int b);
        return 8'(w >> (24 - 8 * b));
    endfunction

    function automatic logic [7:0] model_chk(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++) x = x ^ byte_of(fw[i], b);
        return x;
    endfunction

    task automatic model_expect(input int n);
        if (n >= 1 && n <= int'(DEPTH))
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(ADDR_W'(i));
                exp_data.push_back(fw[i]);
            end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent = 1'b0;
        repeat (gap) @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        for (int k = 0; k < 100 && !sent; k++) begin
            if (o_rx_ready) begin
                @(posedge clk);
                sent = 1'b1;
            end
            @(negedge clk);
        end
        i_rx_valid = 1'b0;
        if (!sent) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_byte_stalled actual=no_ready required=ready byte=0x%0h", b);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("start_busy", 32'(o_busy), 32'd1);
        check("start_cpu_reset", 32'(o_cpu_reset), 32'd1);
        check("start_clears_done", 32'(o_done), 32'd0);
        check("start_clears_error", 32'(o_error), 32'd0);
        check("start_clears_words", 32'(o_words_loaded), 32'd0);
        check("start_clears_addr", 32'(o_imem_addr), 32'd0);
    endtask

    task automatic send_frame(input int n, input logic [7:0] chk, input int gap);
        logic [15:0] nf = 16'(n);
        send_byte(nf[15:8], gap);
        send_byte(nf[7:0], gap);
        if (n > int'(DEPTH)) return;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++) send_byte(byte_of(fw[i], b), gap);
        check("busy_before_chk", 32'(o_busy), 32'd1);
        check("cpu_reset_before_chk", 32'(o_cpu_reset), 32'd1);
        send_byte(chk, gap);
    endtask

    task automatic check_end(input string tag, input int n, input bit ok);
        check({tag, "_done"}, 32'(o_done), 32'(ok));
        check({tag, "_error"}, 32'(o_error), 32'(!ok));
        check({tag, "_cpu_reset"}, 32'(o_cpu_reset), 32'(!ok));
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_rx_ready"}, 32'(o_rx_ready), 32'd0);
        check({tag, "_words_loaded"}, 32'(o_words_loaded), (n > int'(DEPTH)) ? 32'd0 : 32'(n));
        check({tag, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 32'(o_rx_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(o_imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(o_imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, o_imem_wdata, 32'd0);
        check({tag, "_cpu_reset"}, 32'(o_cpu_reset), 32'd1);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_error"}, 32'(o_error), 32'd0);
        check({tag, "_words_loaded"}, 32'(o_words_loaded), 32'd0);
    endtask

    task automatic set_program();
        fw.delete();
        fw.push_back(32'h8C010000);
        fw.push_back(32'h00221820);
    endtask

    initial begin
        bit ok;
        rst_n      = 1'b1;
        i_start    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Good two-word program with the hand-computed checksum
        set_program();
        check("model_chk_pin", 32'(model_chk(2)), 32'h97);
        log_addr.delete(); log_data.delete();
        pulse_start();
        model_expect(2);
        ok = (8'h97 == model_chk(2));
        send_frame(2, 8'h97, 0);
        check_end("good", 2, ok);
        check("good_write_count", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check("good_w0_addr", 32'(log_addr[0]), 32'd0);
            check("good_w0_data", log_data[0], 32'h8C010000);
            check("good_w1_addr", 32'(log_addr[1]), 32'd1);
            check("good_w1_data", log_data[1], 32'h00221820);
        end

        // Corrupted checksum: words still land, core stays held
        pulse_start();
        model_expect(2);
        ok = (8'h96 == model_chk(2));
        send_frame(2, 8'h96, 0);
        check_end("badchk", 2, ok);
        check("badchk_error_lit", 32'(o_error), 32'd1);

        // Empty program
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_frame(0, 8'h00, 0);
        check_end("empty", 0, 1'b1);
        check("empty_no_writes", 32'(log_addr.size()), 32'd0);

        // Oversized length aborts right after LEN_LO
        pulse_start();
        send_frame(1025, 8'h00, 0);
        check_end("toolong", 1025, 1'b0);
        check("toolong_no_writes", 32'(log_addr.size()), 32'd0);

        // Throttled stream with a stray start pulse mid-load
        log_addr.delete(); log_data.delete();
        pulse_start();
        model_expect(2);
        fork
            send_frame(2, model_chk(2), 1);
            begin
                repeat (15) @(negedge clk);
                check("stray_start_while_busy", 32'(o_busy), 32'd1);
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
            end
        join
        check_end("throttled", 2, 1'b1);
        check("throttled_write_count", 32'(log_addr.size()), 32'd2);

        // Stall after three data bytes trips the watchdog on the 16th idle cycle
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_yet", 32'(o_error), 32'd0);
        check("tmo_still_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        check("tmo_error", 32'(o_error), 32'd1);
        check("tmo_not_busy", 32'(o_busy), 32'd0);
        check("tmo_cpu_reset", 32'(o_cpu_reset), 32'd1);

        // Reset while assembling word 1, then a clean reload
        set_program();
        pulse_start();
        exp_addr.push_back(ADDR_W'(0));
        exp_data.push_back(fw[0]);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int b = 0; b < 4; b++) send_byte(byte_of(fw[0], b), 0);
        send_byte(byte_of(fw[1], 0), 0);
        send_byte(byte_of(fw[1], 1), 0);
        check("midreset_busy_before", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        check("midreset_word0_written", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete(); exp_data.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        model_expect(2);
        send_frame(2, model_chk(2), 0);
        check_end("reload", 2, 1'b1);

        // Full-depth load: last write at 1023, address wraps to 0
        fw.delete();
        for (int i = 0; i < int'(DEPTH); i++) fw.push_back({16'(i), 16'(~i)});
        log_addr.delete(); log_data.delete();
        pulse_start();
        model_expect(int'(DEPTH));
        send_frame(int'(DEPTH), model_chk(int'(DEPTH)), 0);
        check_end("full", int'(DEPTH), 1'b1);
        check("full_addr_wrapped", 32'(o_imem_addr), 32'd0);
        check("full_words_lit", 32'(o_words_loaded), 32'd1024);
        check("full_write_count", 32'(log_addr.size()), 32'd1024);
        if (log_addr.size() == 1024) begin
            check("full_last_addr", 32'(log_addr[1023]), 32'd1023);
            check("full_last_data", log_data[1023], 32'h03FFFC00);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
